// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game note lanes.
// Holds the lane FSM states, key codes and the down-arrow sprite.
package rhythm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FALL,
    S_GAP,
    S_DONE
  } lane_state_t;

  localparam logic [7:0] KEY_START = 8'h2C;
  localparam logic [7:0] KEY_RESET = 8'h01;

  // 40x40 down arrow, bit index = row*40 + col.
  // Rows 0..19 are the shaft, rows 20..39 a shrinking head.
  function automatic logic [1599:0] arrow_bits();
    logic [1599:0] b;
    b = '0;
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 40; c++) begin
        if (r < 20) begin
          if (c >= 14 && c < 26)
            b[r*40+c] = 1'b1;
        end else if (c >= r - 20 && c <= 59 - r) begin
          b[r*40+c] = 1'b1;
        end
      end
    end
    return b;
  endfunction

  localparam logic [1599:0] ARROW_DOWN = arrow_bits();

endpackage

// File: rtl/key_edge_detect.sv
// Detects a press of KEY_CODE on either USB keycode input.
// Ports: frame_clk, Reset (async high), keycode, keycode_second -> pressed, press_edge.
module key_edge_detect
  import rhythm_pkg::*;
#(
  parameter logic [7:0] KEY_CODE = 8'h04
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_second,
  output logic       pressed,
  output logic       press_edge
);

  logic r_prev;

  assign pressed = (keycode == KEY_CODE) ||
                   (keycode_second == KEY_CODE);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_prev <= 1'b0;
    else       r_prev <= pressed;
  end

  // Holding the key keeps r_prev high, so only the first frame counts.
  assign press_edge = pressed & ~r_prev;

endmodule

// File: rtl/note_lane.sv
// One configurable rhythm-game lane: spawns falling arrows, judges presses, keeps score.
// Ports: frame_clk, Reset, keycode(s) in; dropX/Y, visible, arrow, hit, miss, score, done
// (+ perfect when NOTE_LANE_PERFECT_EN is defined) out.
module note_lane
  import rhythm_pkg::*;
#(
  parameter int         LANE_X      = 40,
  parameter logic [7:0] KEY_CODE    = 8'h04,
  parameter int         START_DELAY = 960,
  parameter int         NOTE_GAP    = 60,
  parameter int         NUM_NOTES   = 4,
  parameter int         Y_START     = 100,
  parameter int         Y_MAX       = 400,
  parameter int         HIT_LO      = 340,
  parameter int         SPEED       = 1,
  parameter int         SIZE        = 40
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  input  logic [7:0]    keycode_second,
  output logic [9:0]    dropX,
  output logic [9:0]    dropY,
  output logic          visible,
  output logic [1599:0] arrow,
  output logic          hit,
  output logic          miss,
  output logic [7:0]    score,
  output logic          done
`ifdef NOTE_LANE_PERFECT_EN
  ,
  output logic          perfect
`endif
);

  localparam int Y_CLAMP = Y_MAX - SIZE + SPEED;

  lane_state_t   r_state;
  logic [9:0]    r_y;
  logic          r_vis;
  logic [1599:0] r_arrow;
  logic          r_hit;
  logic          r_miss;
  logic [7:0]    r_score;
  logic          r_done;
  logic [7:0]    r_idx;
  logic [15:0]   r_cnt;

  logic          w_pressed;
  logic          w_edge;
  logic [10:0]   w_bottom;
  logic [10:0]   w_y_inc;
  logic [9:0]    w_y_step;
  logic          w_perf;
  logic [8:0]    w_sum;
  logic [7:0]    w_score_next;
  logic          w_last;

  key_edge_detect #(
    .KEY_CODE(KEY_CODE)
  ) u_key (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .pressed       (w_pressed),
    .press_edge    (w_edge)
  );

  assign w_bottom = {1'b0, r_y} + 11'(SIZE);
  assign w_y_inc  = {1'b0, r_y} + 11'(SPEED);
  assign w_y_step = (w_y_inc > 11'(Y_CLAMP)) ?
                    10'(Y_CLAMP) : w_y_inc[9:0];

`ifdef NOTE_LANE_PERFECT_EN
  logic r_perf;
  assign w_perf = (w_bottom >= 11'(Y_MAX - 20)) &&
                  (w_bottom <  11'(Y_MAX - 10));
  assign perfect = r_perf;
`else
  assign w_perf = 1'b0;
`endif

  assign w_sum = {1'b0, r_score} + (w_perf ? 9'd2 : 9'd1);
  assign w_score_next = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_last = (r_idx >= 8'(NUM_NOTES - 1));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_y     <= 10'(Y_START);
      r_vis   <= 1'b0;
      r_arrow <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_score <= '0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
`ifdef NOTE_LANE_PERFECT_EN
      r_perf  <= 1'b0;
`endif
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
`ifdef NOTE_LANE_PERFECT_EN
      r_perf <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          r_score <= '0;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_y     <= 10'(Y_START);
          r_vis   <= 1'b0;
          r_arrow <= '0;
          r_done  <= 1'b0;
          if (keycode == KEY_START)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 16'(START_DELAY - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FALL;
            r_vis   <= 1'b1;
            r_arrow <= ARROW_DOWN;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_FALL: begin
          // Miss takes priority over a same-frame press.
          if (w_bottom >= 11'(Y_MAX) ||
              (w_edge && w_pressed &&
               w_bottom >= 11'(HIT_LO))) begin
            if (w_bottom >= 11'(Y_MAX)) begin
              r_miss <= 1'b1;
            end else begin
              r_hit   <= 1'b1;
              r_score <= w_score_next;
`ifdef NOTE_LANE_PERFECT_EN
              r_perf  <= w_perf;
`endif
            end
            r_vis   <= 1'b0;
            r_arrow <= '0;
            r_cnt   <= '0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_y <= w_y_step;
          end
        end
        S_GAP: begin
          if (r_cnt == 16'(NOTE_GAP - 1)) begin
            r_cnt   <= '0;
            r_y     <= 10'(Y_START);
            r_idx   <= r_idx + 8'd1;
            r_state <= S_FALL;
            r_vis   <= 1'b1;
            r_arrow <= ARROW_DOWN;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          if (keycode == KEY_RESET) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dropX   = 10'(LANE_X);
  assign dropY   = r_y;
  assign visible = r_vis;
  assign arrow   = r_arrow;
  assign hit     = r_hit;
  assign miss    = r_miss;
  assign score   = r_score;
  assign done    = r_done;

endmodule

// File: tb/tb_note_lane.sv
// Directed self-checking bench for note_lane with default parameters.
// Covers reset, full miss run, hit windows, key hold and DONE handling.
module tb_note_lane;

  logic          clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic [7:0]    keycode_second;
  logic [9:0]    dropX;
  logic [9:0]    dropY;
  logic          visible;
  logic [1599:0] arrow;
  logic          hit;
  logic          miss;
  logic [7:0]    score;
  logic          done;
`ifdef NOTE_LANE_PERFECT_EN
  logic          perfect;
`endif

  int tests = 0;
  int fails = 0;
  int hcount;

  note_lane dut (
    .frame_clk     (clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .dropX         (dropX),
    .dropY         (dropY),
    .visible       (visible),
    .arrow         (arrow),
    .hit           (hit),
    .miss          (miss),
    .score         (score),
    .done          (done)
`ifdef NOTE_LANE_PERFECT_EN
    ,
    .perfect       (perfect)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gap_to_fall();
    tick();
    tick_n(58);
    check("gap_vis_low", 16'(visible), 16'd0);
    tick();
    check("gap_vis_high", 16'(visible), 16'd1);
    check("gap_y_start", 16'(dropY), 16'd100);
  endtask

  initial begin
    Reset = 1'b1;
    keycode = 8'h00;
    keycode_second = 8'h00;
    tick_n(2);
    check("rst_x", 16'(dropX), 16'd40);
    check("rst_y", 16'(dropY), 16'd100);
    check("rst_vis", 16'(visible), 16'd0);
    check("rst_arrow", 16'(arrow != '0), 16'd0);
    check("rst_hit", 16'(hit), 16'd0);
    check("rst_miss", 16'(miss), 16'd0);
    check("rst_score", 16'(score), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    Reset = 1'b0;
    tick();

    // Start, then reset asynchronously mid-fall at Y=250.
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tick_n(959);
    check("wait_vis", 16'(visible), 16'd0);
    tick();
    check("spawn_vis", 16'(visible), 16'd1);
    check("spawn_y", 16'(dropY), 16'd100);
    check("spawn_arrow", 16'(arrow == rhythm_pkg::ARROW_DOWN), 16'd1);
    check("arrow_tip", 16'(arrow[39*40+19]), 16'd1);
    check("arrow_corner", 16'(arrow[0]), 16'd0);
    tick_n(150);
    check("fall_y250", 16'(dropY), 16'd250);
    Reset = 1'b1;
    #1;
    check("async_y", 16'(dropY), 16'd100);
    check("async_vis", 16'(visible), 16'd0);
    check("async_score", 16'(score), 16'd0);
    check("async_arrow", 16'(arrow != '0), 16'd0);
    tick();
    Reset = 1'b0;
    tick();

    // Full run with no presses: four misses.
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tick_n(960);
    check("run_vis", 16'(visible), 16'd1);
    for (int n = 0; n < 4; n++) begin
      tick_n(260);
      check("pre_miss_y", 16'(dropY), 16'd360);
      check("pre_miss", 16'(miss), 16'd0);
      tick();
      check("miss_pulse", 16'(miss), 16'd1);
      check("miss_vis", 16'(visible), 16'd0);
      check("miss_y_held", 16'(dropY), 16'd360);
      if (n < 3) begin
        check("miss_not_done", 16'(done), 16'd0);
        gap_to_fall();
      end else begin
        check("run_done", 16'(done), 16'd1);
        check("run_score", 16'(score), 16'd0);
        tick();
        check("miss_one_frame", 16'(miss), 16'd0);
      end
    end

    // Space in DONE is ignored; 8'h01 returns to IDLE.
    keycode = 8'h2C;
    tick();
    tick();
    keycode = 8'h00;
    check("space_in_done", 16'(done), 16'd1);
    check("space_no_vis", 16'(visible), 16'd0);
    keycode = 8'h01;
    tick();
    keycode = 8'h00;
    check("exit_done", 16'(done), 16'd0);

    // Note 1: hit via keycode_second at bottom 345.
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tick_n(960);
    tick_n(205);
    check("n1_y", 16'(dropY), 16'd305);
    keycode_second = 8'h04;
    tick();
    check("n1_hit", 16'(hit), 16'd1);
    check("n1_score", 16'(score), 16'd1);
    check("n1_vis", 16'(visible), 16'd0);
    check("n1_y_held", 16'(dropY), 16'd305);
    keycode_second = 8'h00;
    tick_n(0);
    gap_to_fall();

    // Note 2: hold from bottom 300 through 399, then miss.
    tick_n(160);
    check("n2_y", 16'(dropY), 16'd260);
    keycode = 8'h04;
    hcount = 0;
    repeat (100) begin
      tick();
      if (hit) hcount++;
    end
    check("n2_no_hit", 16'(hcount), 16'd0);
    check("n2_y360", 16'(dropY), 16'd360);
    tick();
    check("n2_miss", 16'(miss), 16'd1);
    check("n2_score", 16'(score), 16'd1);
    keycode = 8'h00;
    gap_to_fall();

    // Note 3: early press at 339 ignored, second at 341 scores.
    tick_n(199);
    check("n3_y", 16'(dropY), 16'd299);
    keycode = 8'h04;
    tick();
    check("n3_early", 16'(hit), 16'd0);
    check("n3_y300", 16'(dropY), 16'd300);
    keycode = 8'h00;
    tick();
    check("n3_y301", 16'(dropY), 16'd301);
    keycode = 8'h04;
    tick();
    check("n3_hit", 16'(hit), 16'd1);
    check("n3_score", 16'(score), 16'd2);
    keycode = 8'h00;
    gap_to_fall();

    // Note 4: press at bottom 400 counts as a miss.
    tick_n(260);
    check("n4_y", 16'(dropY), 16'd360);
    keycode = 8'h04;
    keycode_second = 8'h04;
    tick();
    check("n4_miss", 16'(miss), 16'd1);
    check("n4_no_hit", 16'(hit), 16'd0);
    check("n4_done", 16'(done), 16'd1);
    check("n4_score", 16'(score), 16'd2);
    keycode = 8'h01;
    keycode_second = 8'h00;
    tick();
    keycode = 8'h00;
    tick();
    check("idle_score", 16'(score), 16'd0);
    check("idle_done", 16'(done), 16'd0);

`ifdef NOTE_LANE_PERFECT_EN
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    tick_n(960);
    tick_n(245);
    keycode = 8'h04;
    tick();
    check("pf_perfect", 16'(perfect), 16'd1);
    check("pf_hit", 16'(hit), 16'd1);
    check("pf_score", 16'(score), 16'd2);
    keycode = 8'h00;
    gap_to_fall();
    tick_n(255);
    keycode = 8'h04;
    tick();
    check("pf2_perfect", 16'(perfect), 16'd0);
    check("pf2_hit", 16'(hit), 16'd1);
    check("pf2_score", 16'(score), 16'd3);
    keycode = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
